// File: rtl/scp_ctrl_pkg.sv
// Shared definitions for the program-counter sequencing controller:
// state encodings, the jump vector, and the bundle of combinational strobes.
package scp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_IRQ   = 3'd4,
    ST_HALT  = 3'd5
  } ctrl_state_e;

  localparam logic [15:0] PC_VECTOR = 16'hFFF0;
  localparam int unsigned TIMER_W   = 8;

  typedef struct packed {
    logic mem_req;
    logic ir_we;
    logic pc_inc;
    logic pc_bus_we;
    logic pc_mdr_we;
    logic pc_jmpfff0;
    logic irq_ack;
    logic halted;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_IDLE = '0;

endpackage

// File: rtl/fetch_timer.sv
// Counts WAIT cycles that pass without a memory acknowledge.
// The limit flag is ungated so the FSM can qualify it with the acknowledge.
module fetch_timer
  import scp_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  // expire marks the last permitted WAIT cycle, i.e. the TIMEOUT-th one.
  assign expire = (count == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/execute sequencer: boots to the reset vector, fetches via a
// request/acknowledge handshake, hands off to the execute unit, services IRQ/halt.
module pc_seq_ctrl
  import scp_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  input  logic       mem_ack,
  output logic       ir_we,
  output logic       pc_inc,
  output logic       pc_bus_we,
  output logic       pc_mdr_we,
  output logic       pc_jmpfff0,
  output logic       exec_start,
  input  logic       exec_done,
  input  logic       jmp_bus,
  input  logic       jmp_mdr,
  input  logic       irq,
  output logic       irq_ack,
  input  logic       halt_req,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  ctrl_state_e cur_state;
  ctrl_state_e next_state;
  ctrl_out_t   co;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_expire;
  logic        set_fault;
  logic        enter_exec;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state  <= ST_BOOT;
      exec_start <= 1'b0;
      fault      <= 1'b0;
    end else begin
      cur_state  <= next_state;
      exec_start <= enter_exec;
      if (set_fault) begin
        fault <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state  = cur_state;
    co          = CTRL_IDLE;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    set_fault   = 1'b0;
    enter_exec  = 1'b0;
    case (cur_state)
      ST_BOOT: begin
        co.pc_jmpfff0 = 1'b1;
        next_state    = ST_FETCH;
      end
      ST_FETCH: begin
        co.mem_req  = 1'b1;
        timer_clear = 1'b1;
        next_state  = ST_WAIT;
      end
      ST_WAIT: begin
        co.mem_req = 1'b1;
        // An acknowledge in the final permitted cycle still wins over the timeout.
        if (mem_ack) begin
          co.ir_we   = 1'b1;
          co.pc_inc  = 1'b1;
          enter_exec = 1'b1;
          next_state = ST_EXEC;
        end else begin
          timer_en = 1'b1;
          if (timer_expire) begin
            set_fault  = 1'b1;
            next_state = ST_HALT;
          end
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (jmp_mdr) begin
            co.pc_mdr_we = 1'b1;
          end else if (jmp_bus) begin
            co.pc_bus_we = 1'b1;
          end
          if (halt_req) begin
            next_state = ST_HALT;
          end else if (irq) begin
            next_state = ST_IRQ;
          end else begin
            next_state = ST_FETCH;
          end
        end
      end
      ST_IRQ: begin
        co.irq_ack    = 1'b1;
        co.pc_jmpfff0 = 1'b1;
        next_state    = ST_FETCH;
      end
      ST_HALT: begin
        co.halted = 1'b1;
        if (!halt_req && !fault) begin
          next_state = ST_FETCH;
        end
      end
      default: begin
        next_state = ST_BOOT;
      end
    endcase
  end

  // Strobes are gated by reset so the BOOT decode stays silent while rst is low.
  assign mem_req    = rst & co.mem_req;
  assign ir_we      = rst & co.ir_we;
  assign pc_inc     = rst & co.pc_inc;
  assign pc_bus_we  = rst & co.pc_bus_we;
  assign pc_mdr_we  = rst & co.pc_mdr_we;
  assign pc_jmpfff0 = rst & co.pc_jmpfff0;
  assign irq_ack    = rst & co.irq_ack;
  assign halted     = rst & co.halted;
  assign state      = cur_state;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed, table-driven bench for pc_seq_ctrl with a short timeout,
// plus hand-written sequences for asynchronous reset and the timeout boundary.
module tb_pc_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic       mem_ack;
  logic       ir_we;
  logic       pc_inc;
  logic       pc_bus_we;
  logic       pc_mdr_we;
  logic       pc_jmpfff0;
  logic       exec_start;
  logic       exec_done;
  logic       jmp_bus;
  logic       jmp_mdr;
  logic       irq;
  logic       irq_ack;
  logic       halt_req;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  pc_seq_ctrl #(
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .ir_we      (ir_we),
    .pc_inc     (pc_inc),
    .pc_bus_we  (pc_bus_we),
    .pc_mdr_we  (pc_mdr_we),
    .pc_jmpfff0 (pc_jmpfff0),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .jmp_bus    (jmp_bus),
    .jmp_mdr    (jmp_mdr),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .halt_req   (halt_req),
    .halted     (halted),
    .fault      (fault),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // inputs:  {rst, mem_ack, exec_done, jmp_bus, jmp_mdr, irq, halt_req}
  // outputs: {mem_req, ir_we, pc_inc, pc_bus_we, pc_mdr_we, pc_jmpfff0,
  //           exec_start, irq_ack, halted, fault}
  typedef struct {
    string      name;
    logic [6:0] in;
    logic [2:0] st;
    logic [9:0] out;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [9:0] act_out;
  assign act_out = {mem_req, ir_we, pc_inc, pc_bus_we, pc_mdr_we, pc_jmpfff0,
                    exec_start, irq_ack, halted, fault};

  function automatic vec_t mk(string nm, logic [6:0] in, logic [2:0] st, logic [9:0] o);
    vec_t v;
    v.name = nm;
    v.in   = in;
    v.st   = st;
    v.out  = o;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [6:0] in);
    {rst, mem_ack, exec_done, jmp_bus, jmp_mdr, irq, halt_req} = in;
  endtask

  initial begin
    drive(7'b0000000);

    vecs.push_back(mk("reset_hold",     7'b0000000, 3'd0, 10'b0000000000));
    vecs.push_back(mk("boot_vector",    7'b1000000, 3'd0, 10'b0000010000));
    vecs.push_back(mk("fetch_req",      7'b1000000, 3'd1, 10'b1000000000));
    vecs.push_back(mk("wait_no_ack",    7'b1000000, 3'd2, 10'b1000000000));
    vecs.push_back(mk("wait_ack",       7'b1100000, 3'd2, 10'b1110000000));
    vecs.push_back(mk("exec_start",     7'b1000000, 3'd3, 10'b0000001000));
    vecs.push_back(mk("jmp_mdr_prio",   7'b1011100, 3'd3, 10'b0000100000));
    vecs.push_back(mk("fetch_after_j",  7'b1000000, 3'd1, 10'b1000000000));
    vecs.push_back(mk("wait_ack_fast",  7'b1100000, 3'd2, 10'b1110000000));
    vecs.push_back(mk("exec_bus_irq",   7'b1011010, 3'd3, 10'b0001001000));
    vecs.push_back(mk("irq_service",    7'b1000010, 3'd4, 10'b0000010100));
    vecs.push_back(mk("fetch_ign_irq",  7'b1000011, 3'd1, 10'b1000000000));
    vecs.push_back(mk("wait_ign_halt",  7'b1100011, 3'd2, 10'b1110000000));
    vecs.push_back(mk("exec_halt_irq",  7'b1010011, 3'd3, 10'b0000001000));
    vecs.push_back(mk("halt_held",      7'b1000011, 3'd5, 10'b0000000010));
    vecs.push_back(mk("halt_release",   7'b1000000, 3'd5, 10'b0000000010));
    vecs.push_back(mk("fetch_from_h",   7'b1000000, 3'd1, 10'b1000000000));
    vecs.push_back(mk("wait_to_1",      7'b1000000, 3'd2, 10'b1000000000));
    vecs.push_back(mk("wait_to_2",      7'b1000000, 3'd2, 10'b1000000000));
    vecs.push_back(mk("wait_to_3",      7'b1000000, 3'd2, 10'b1000000000));
    vecs.push_back(mk("wait_to_4",      7'b1000000, 3'd2, 10'b1000000000));
    vecs.push_back(mk("fault_halt",     7'b1000000, 3'd5, 10'b0000000011));
    vecs.push_back(mk("fault_sticky",   7'b1000000, 3'd5, 10'b0000000011));
    vecs.push_back(mk("fault_ign_in",   7'b1110000, 3'd5, 10'b0000000011));
    vecs.push_back(mk("reset_clr_flt",  7'b0000000, 3'd0, 10'b0000000000));
    vecs.push_back(mk("boot_again",     7'b1000000, 3'd0, 10'b0000010000));
    vecs.push_back(mk("fetch_again",    7'b1000000, 3'd1, 10'b1000000000));
    vecs.push_back(mk("wait_again",     7'b1000000, 3'd2, 10'b1000000000));
    vecs.push_back(mk("reset_in_wait",  7'b0000000, 3'd0, 10'b0000000000));
    vecs.push_back(mk("boot_restart",   7'b1000000, 3'd0, 10'b0000010000));
    vecs.push_back(mk("fetch_restart",  7'b1000000, 3'd1, 10'b1000000000));
    vecs.push_back(mk("wait_restart",   7'b1000000, 3'd2, 10'b1000000000));
    vecs.push_back(mk("ack_restart",    7'b1100000, 3'd2, 10'b1110000000));
    vecs.push_back(mk("exec_st_rst",    7'b1000000, 3'd3, 10'b0000001000));
    vecs.push_back(mk("exec_one_pulse", 7'b1000000, 3'd3, 10'b0000000000));
    vecs.push_back(mk("exec_plain",     7'b1010000, 3'd3, 10'b0000000000));
    vecs.push_back(mk("fetch_plain",    7'b1000000, 3'd1, 10'b1000000000));

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      @(negedge clk);
      total_cnt++;
      if (state === vecs[i].st && act_out === vecs[i].out) begin
        pass_cnt++;
      end else begin
        $display("FAIL %s: got state=%0d out=%b expected state=%0d out=%b",
                 vecs[i].name, state, act_out, vecs[i].st, vecs[i].out);
      end
      chk({vecs[i].name, "_excl"},
          32'(($countones({pc_inc, pc_bus_we, pc_mdr_we, pc_jmpfff0}) <= 1)), 32'd1);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-fetch: outputs fall without waiting for an edge.
    drive(7'b1000000);
    #1;
    chk("pre_async_state", 32'(state), 32'd2);
    chk("pre_async_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_req_drop", 32'(mem_req), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_vector", 32'(pc_jmpfff0), 32'd1);

    // Acknowledge in the last permitted WAIT cycle is taken, no fault.
    @(posedge clk);
    #1;
    chk("bnd_fetch", 32'(state), 32'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bnd_wait", 32'(state), 32'd2);
    end
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    #1;
    chk("bnd_ack_irwe", 32'({state, ir_we, pc_inc, mem_req}), 32'({3'd2, 3'b111}));
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    #1;
    chk("bnd_exec", 32'({state, exec_start, fault, halted}), 32'({3'd3, 3'b100}));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles in WAIT before fetch fault (8-bit, 1..255).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 mem_req  out  1  fetch request to memory at current PC.
REQ-005 mem_ack  in  1  memory word valid this cycle.
REQ-006 ir_we  out  1  latch memory word into instruction register.
REQ-007 pc_inc  out  1  PC increment strobe.
REQ-008 pc_bus_we / pc_mdr_we / pc_jmpfff0  out  1 each  PC load strobes (bus, MDR, vector 0xFFF0).
REQ-009 exec_start  out  1  one-cycle pulse: execute unit begins instruction.
REQ-010 exec_done  in  1  execute unit finished; sampled only in EXEC.
REQ-011 jmp_bus / jmp_mdr  in  1 each  jump request qualifying exec_done.
REQ-012 irq  in  1  level interrupt request; irq_ack  out  1  one-cycle acknowledge.
REQ-013 halt_req  in  1  stop request; halted  out  1  controller in HALT.
REQ-014 fault  out  1  sticky fetch-timeout flag; state  out  3  current state encoding.

Function
REQ-015 States: BOOT=0, FETCH=1, WAIT=2, EXEC=3, IRQ=4, HALT=5; codes 6-7 SHALL go to BOOT next cycle.
REQ-016 BOOT: assert pc_jmpfff0 one cycle, then FETCH.
REQ-017 FETCH: assert mem_req, clear wait counter, go WAIT.
REQ-018 WAIT: hold mem_req; on mem_ack assert ir_we and pc_inc same cycle, go EXEC with exec_start pulsed on the entering edge's following cycle (exactly one cycle).
REQ-019 WAIT: counter +1 per cycle without ack; reaching TIMEOUT sets fault, drops mem_req, goes HALT.
REQ-020 EXEC: wait for exec_done; at exec_done, jmp_mdr has priority over jmp_bus (asserts pc_mdr_we, else pc_bus_we), at most one PC strobe per cycle.
REQ-021 EXEC exit priority at exec_done: halt_req -> HALT; else irq -> IRQ; else FETCH.
REQ-022 IRQ: assert irq_ack and pc_jmpfff0 one cycle, then FETCH; irq ignored outside EXEC completion.
REQ-023 HALT: halted=1, all strobes 0; leave only when halt_req=0 and fault=0, to FETCH.
REQ-024 Strobes pc_inc, pc_bus_we, pc_mdr_we, pc_jmpfff0 SHALL be mutually exclusive every cycle.
REQ-025 halt_req in FETCH/WAIT SHALL NOT abort an in-flight fetch; honoured at next exec_done.
REQ-026 Fetch latency: FETCH to ir_we = 1 + ack delay cycles; minimum instruction period 3 cycles + exec length.

Reset
REQ-027 rst low: state=BOOT, counter=0, fault=0, all outputs 0 except state=0, asynchronously.
REQ-028 Deassertion mid-fetch: no residual mem_req; first post-reset cycle asserts pc_jmpfff0.
REQ-029 fault cleared only by reset.

Structure
REQ-030 State encodings and vector constant 16'hFFF0 SHALL live in shared package scp_ctrl_pkg.
REQ-031 Timeout counter SHALL be sub-module fetch_timer (clear, enable, expire) ; remainder single FSM with registered state, combinational strobes.

Verification
REQ-032 Reset release, mem_ack 2 cycles after mem_req -> pc_jmpfff0 cycle 1, mem_req cycle 2, ir_we+pc_inc cycle 4, exec_start cycle 5.
REQ-033 exec_done with jmp_bus=1, jmp_mdr=1 -> pc_mdr_we only, pc_bus_we=0, next state FETCH.
REQ-034 irq=1 and halt_req=1 at exec_done -> HALT, no irq_ack; drop halt_req -> FETCH next cycle.
REQ-035 irq=1 at exec_done -> IRQ one cycle with irq_ack=1, pc_jmpfff0=1, then FETCH.
REQ-036 TIMEOUT=4, mem_ack never -> fault=1 after 4 WAIT cycles, halted=1, persists with halt_req=0 until rst.
REQ-037 rst pulsed low during WAIT -> mem_req falls immediately, state=0, restart sequence per REQ-032.
